// File: rtl/fetch_prefetch_unit_if.sv
// Bundles the imem request/response bus and the decoder-facing instruction stream.
// The master modport is the fetch unit; the slave modport is the memory/decoder side.
interface fetch_prefetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WORD_WIDTH = 32
);
    logic                  imem_valid_o;
    logic                  imem_ready_i;
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic [WORD_WIDTH-1:0] imem_wdata_o;
    logic [3:0]            imem_we_o;
    logic [WORD_WIDTH-1:0] imem_rdata_i;

    logic [WORD_WIDTH-1:0] instr_o;
    logic [ADDR_WIDTH-1:0] instr_addr_o;
    logic                  instr_valid_o;
    logic                  instr_ready_i;

    modport master (
        output imem_valid_o,
        output imem_addr_o,
        output imem_wdata_o,
        output imem_we_o,
        input  imem_ready_i,
        input  imem_rdata_i,
        output instr_o,
        output instr_addr_o,
        output instr_valid_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_valid_o,
        input  imem_addr_o,
        input  imem_wdata_o,
        input  imem_we_o,
        output imem_ready_i,
        output imem_rdata_i,
        input  instr_o,
        input  instr_addr_o,
        input  instr_valid_o,
        output instr_ready_i
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Prefetching fetch stage: DEPTH-entry {addr, instr} FIFO between imem and the decoder.
// Macro FETCH_BYPASS_EN forwards a response straight to the decoder when the FIFO is empty.
module fetch_prefetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           WORD_WIDTH = 32,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] target_addr_i,
    input  logic                  target_valid_i,
    fetch_prefetch_unit_if.master bus
);
    localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CntW     = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StBusy, StDiscard} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [WORD_WIDTH-1:0] data_mem_q [DEPTH];

    logic                  fifo_empty;
    logic                  issue_idle;
    logic                  imem_valid;
    logic                  hs;
    logic                  bypass;
    logic                  bypass_take;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] target_aligned;

    assign fifo_empty     = (count_q == '0);
    assign target_aligned = {target_addr_i[ADDR_WIDTH-1:2], 2'b00};

    // A request is live in BUSY/DISCARD, or starts combinationally from IDLE.
    assign issue_idle = (state_q == StIdle) && req_i && (count_q < DepthCnt);
    assign imem_valid = issue_idle || (state_q != StIdle);
    assign hs         = imem_valid && bus.imem_ready_i;

    assign bus.imem_valid_o = imem_valid;
    assign bus.imem_addr_o  = (state_q == StDiscard) ? hold_addr_q : fetch_pc_q;
    assign bus.imem_wdata_o = '0;
    assign bus.imem_we_o    = 4'b0000;

`ifdef FETCH_BYPASS_EN
    assign bypass = fifo_empty && (state_q != StDiscard) && !target_valid_i && hs;
`else
    assign bypass = 1'b0;
`endif
    assign bypass_take = bypass && bus.instr_ready_i;

    // Redirect flushes the FIFO, so both a same-cycle push and pop are suppressed.
    assign push = hs && (state_q != StDiscard) && !target_valid_i && !bypass_take;
    assign pop  = !fifo_empty && bus.instr_ready_i && !target_valid_i;

    always_comb begin
        bus.instr_valid_o = !fifo_empty || bypass;
        bus.instr_o       = '0;
        bus.instr_addr_o  = '0;
        if (bypass) begin
            bus.instr_o      = bus.imem_rdata_i;
            bus.instr_addr_o = fetch_pc_q;
        end else if (!fifo_empty) begin
            bus.instr_o      = data_mem_q[rd_ptr_q];
            bus.instr_addr_o = addr_mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (target_valid_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CntW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        hold_addr_d = hold_addr_q;
        unique case (state_q)
            StIdle, StBusy: begin
                if (target_valid_i) begin
                    fetch_pc_d = target_aligned;
                    // An unanswered request cannot be withdrawn; wait it out and drop it.
                    if (imem_valid && !bus.imem_ready_i) begin
                        state_d     = StDiscard;
                        hold_addr_d = fetch_pc_q;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (hs) begin
                    fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
                    state_d    = (req_i && (count_d < DepthCnt)) ? StBusy : StIdle;
                end else if (issue_idle) begin
                    state_d = StBusy;
                end
            end
            StDiscard: begin
                if (target_valid_i) begin
                    fetch_pc_d = target_aligned;
                end
                if (bus.imem_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            fetch_pc_q  <= RESET_ADDR;
            hold_addr_q <= RESET_ADDR;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            hold_addr_q <= hold_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= fetch_pc_q;
            data_mem_q[wr_ptr_q] <= bus.imem_rdata_i;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: directed scenarios plus a randomized run
// checked against a stream-level model (consumed addresses are consecutive from the last target).
module tb_fetch_prefetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] target_addr = '0;
    logic        target_valid = 1'b0;
    logic        req8 = 1'b0;
    logic [7:0]  target_addr8 = '0;
    logic        target_valid8 = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_prefetch_unit_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) bus ();
    fetch_prefetch_unit_if #(.ADDR_WIDTH(8), .WORD_WIDTH(32)) bus8 ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.imem_rdata_i  = mem_word(bus.imem_addr_o);
    assign bus8.imem_rdata_i = mem_word({24'h0, bus8.imem_addr_o});

    fetch_prefetch_unit #(
        .ADDR_WIDTH(32), .WORD_WIDTH(32), .DEPTH(4), .RESET_ADDR(32'h0000_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .target_addr_i(target_addr),
        .target_valid_i(target_valid), .bus(bus)
    );

    fetch_prefetch_unit #(
        .ADDR_WIDTH(8), .WORD_WIDTH(32), .DEPTH(4), .RESET_ADDR(8'hFC)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .req_i(req8), .target_addr_i(target_addr8),
        .target_valid_i(target_valid8), .bus(bus8)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        req = 1'b0;
        target_valid = 1'b0;
        target_addr = '0;
        bus.imem_ready_i = 1'b0;
        bus.instr_ready_i = 1'b0;
        req8 = 1'b0;
        target_valid8 = 1'b0;
        target_addr8 = '0;
        bus8.imem_ready_i = 1'b0;
        bus8.instr_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req = 1'b1; bus.imem_ready_i = 1'b1; bus.instr_ready_i = 1'b0;
        end
        @(negedge clk);
        req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.instr_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid_o);
        end
        checks++;
        if (bus.imem_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_imem_valid: got %b want 0", bus.imem_valid_o);
        end
        checks++;
        if (bus.imem_addr_o !== 32'h0) begin
            errors++; $display("FAIL reset_imem_addr: got %h want 0", bus.imem_addr_o);
        end
        checks++;
        if (bus.instr_o !== 32'h0 || bus.instr_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_instr_regs: got %h/%h want 0/0", bus.instr_o, bus.instr_addr_o);
        end
        checks++;
        if (bus.imem_we_o !== 4'b0000 || bus.imem_wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_tieoffs: got we=%b wdata=%h want 0", bus.imem_we_o,
                     bus.imem_wdata_o);
        end
        checks++;
        if (bus8.imem_addr_o !== 8'hFC) begin
            errors++; $display("FAIL reset_addr8: got %h want fc", bus8.imem_addr_o);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_a;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req = 1'b1; bus.imem_ready_i = 1'b1; bus.instr_ready_i = 1'b1;
            #1;
            if (k < 4) begin
                checks++;
                if (bus.imem_valid_o !== 1'b1 || bus.imem_addr_o !== 32'(4 * k)) begin
                    errors++;
                    $display("FAIL seq_req%0d: got v=%b a=%h want v=1 a=%h", k,
                             bus.imem_valid_o, bus.imem_addr_o, 32'(4 * k));
                end
            end
`ifdef FETCH_BYPASS_EN
            exp_a = 32'(4 * k);
`else
            exp_a = 32'(4 * (k - 1));
            if (k == 0) begin
                checks++;
                if (bus.instr_valid_o !== 1'b0) begin
                    errors++; $display("FAIL seq_latency: got valid=%b want 0", bus.instr_valid_o);
                end
                continue;
            end
`endif
            checks++;
            if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== exp_a ||
                bus.instr_o !== mem_word(exp_a)) begin
                errors++;
                $display("FAIL seq_instr%0d: got v=%b a=%h d=%h want v=1 a=%h d=%h", k,
                         bus.instr_valid_o, bus.instr_addr_o, bus.instr_o, exp_a,
                         mem_word(exp_a));
            end
        end
    endtask

    task automatic test_fill();
        int n_hs;
        do_reset();
        n_hs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req = 1'b1; bus.imem_ready_i = 1'b1; bus.instr_ready_i = 1'b0;
            #1;
            if (bus.imem_valid_o) n_hs++;
        end
        checks++;
        if (n_hs != 4 || bus.imem_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_count: got %0d txns valid=%b want 4 txns valid=0", n_hs,
                     bus.imem_valid_o);
        end
        @(negedge clk);
        bus.instr_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL fill_head: got v=%b a=%h want v=1 a=0", bus.instr_valid_o,
                     bus.instr_addr_o);
        end
        n_hs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.instr_ready_i = 1'b0;
            #1;
            if (bus.imem_valid_o) begin
                n_hs++;
                checks++;
                if (bus.imem_addr_o !== 32'h10) begin
                    errors++; $display("FAIL fill_refill_addr: got %h want 10", bus.imem_addr_o);
                end
            end
        end
        checks++;
        if (n_hs != 1) begin
            errors++; $display("FAIL fill_refill_count: got %0d want 1", n_hs);
        end
    endtask

    task automatic test_redirect_discard();
        logic saw_req, saw_instr;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req = 1'b1; bus.imem_ready_i = 1'b1; bus.instr_ready_i = 1'b1;
        end
        @(negedge clk);
        bus.imem_ready_i = 1'b0;
        #1;
        checks++;
        if (bus.imem_valid_o !== 1'b1 || bus.imem_addr_o !== 32'h10) begin
            errors++;
            $display("FAIL disc_pending: got v=%b a=%h want v=1 a=10", bus.imem_valid_o,
                     bus.imem_addr_o);
        end
        @(negedge clk);
        target_valid = 1'b1; target_addr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            target_valid = 1'b0;
            #1;
            checks++;
            if (bus.imem_valid_o !== 1'b1 || bus.imem_addr_o !== 32'h10 ||
                bus.instr_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL disc_hold%0d: got v=%b a=%h iv=%b want v=1 a=10 iv=0", i,
                         bus.imem_valid_o, bus.imem_addr_o, bus.instr_valid_o);
            end
        end
        @(negedge clk);
        bus.imem_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.imem_addr_o !== 32'h10 || bus.instr_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL disc_drop: got a=%h iv=%b want a=10 iv=0", bus.imem_addr_o,
                     bus.instr_valid_o);
        end
        saw_req = 1'b0;
        saw_instr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (!saw_req && bus.imem_valid_o) begin
                saw_req = 1'b1;
                checks++;
                if (bus.imem_addr_o !== 32'h100) begin
                    errors++; $display("FAIL disc_next_req: got %h want 100", bus.imem_addr_o);
                end
            end
            if (!saw_instr && bus.instr_valid_o) begin
                saw_instr = 1'b1;
                checks++;
                if (bus.instr_addr_o !== 32'h100 || bus.instr_o !== mem_word(32'h100)) begin
                    errors++;
                    $display("FAIL disc_first_instr: got a=%h d=%h want a=100 d=%h",
                             bus.instr_addr_o, bus.instr_o, mem_word(32'h100));
                end
            end
        end
        if (!saw_req || !saw_instr) begin
            checks++; errors++;
            $display("FAIL disc_timeout: got req=%b instr=%b want both 1", saw_req, saw_instr);
        end
    endtask

    task automatic test_redirect_coincide();
        logic found, saw;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req = 1'b1; bus.imem_ready_i = 1'b1; bus.instr_ready_i = 1'b1; target_valid = 1'b0;
            #1;
            if (bus.imem_valid_o && bus.imem_addr_o == 32'h20) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL coin_reach: got no request at 20 want one");
        end
        target_valid = 1'b1;
        target_addr = 32'h102;
        @(negedge clk);
        target_valid = 1'b0;
        bus.imem_ready_i = 1'b0;
        #1;
        checks++;
        if (bus.instr_valid_o !== 1'b0) begin
            errors++; $display("FAIL coin_flush: got iv=%b want 0", bus.instr_valid_o);
        end
        checks++;
        if (bus.imem_valid_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin
            errors++;
            $display("FAIL coin_next_req: got v=%b a=%h want v=1 a=100", bus.imem_valid_o,
                     bus.imem_addr_o);
        end
        saw = 1'b0;
        for (int i = 0; i < 8 && !saw; i++) begin
            @(negedge clk);
            bus.imem_ready_i = 1'b1;
            #1;
            if (bus.instr_valid_o) begin
                saw = 1'b1;
                checks++;
                if (bus.instr_addr_o !== 32'h100) begin
                    errors++; $display("FAIL coin_first_instr: got %h want 100", bus.instr_addr_o);
                end
            end
        end
        if (!saw) begin
            checks++; errors++; $display("FAIL coin_timeout: got no instr want addr 100");
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_ia;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req8 = 1'b1; bus8.imem_ready_i = 1'b1; bus8.instr_ready_i = 1'b1;
            #1;
            checks++;
            if (bus8.imem_valid_o !== 1'b1 || bus8.imem_addr_o !== (i == 0 ? 8'hFC : 8'h00)) begin
                errors++;
                $display("FAIL wrap_req%0d: got v=%b a=%h want v=1 a=%h", i, bus8.imem_valid_o,
                         bus8.imem_addr_o, (i == 0 ? 8'hFC : 8'h00));
            end
        end
`ifdef FETCH_BYPASS_EN
        exp_ia = 8'h00;
`else
        exp_ia = 8'hFC;
`endif
        checks++;
        if (bus8.instr_valid_o !== 1'b1 || bus8.instr_addr_o !== exp_ia) begin
            errors++;
            $display("FAIL wrap_instr: got v=%b a=%h want v=1 a=%h", bus8.instr_valid_o,
                     bus8.instr_addr_o, exp_ia);
        end
        req8 = 1'b0;
    endtask

    task automatic test_bypass();
        do_reset();
        @(negedge clk);
        target_valid = 1'b1; target_addr = 32'h40;
        @(negedge clk);
        target_valid = 1'b0; req = 1'b1; bus.imem_ready_i = 1'b1; bus.instr_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.imem_valid_o !== 1'b1 || bus.imem_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL byp_req: got v=%b a=%h want v=1 a=40", bus.imem_valid_o,
                     bus.imem_addr_o);
        end
`ifdef FETCH_BYPASS_EN
        checks++;
        if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'hDEAD_BEEF ||
            bus.instr_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL byp_same_cycle: got v=%b d=%h a=%h want v=1 d=deadbeef a=40",
                     bus.instr_valid_o, bus.instr_o, bus.instr_addr_o);
        end
`else
        checks++;
        if (bus.instr_valid_o !== 1'b0) begin
            errors++; $display("FAIL byp_same_cycle: got v=%b want 0", bus.instr_valid_o);
        end
`endif
        @(negedge clk);
        req = 1'b0; bus.imem_ready_i = 1'b0;
        #1;
`ifdef FETCH_BYPASS_EN
        checks++;
        if (bus.instr_valid_o !== 1'b0) begin
            errors++; $display("FAIL byp_not_pushed: got v=%b want 0", bus.instr_valid_o);
        end
`else
        checks++;
        if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'hDEAD_BEEF ||
            bus.instr_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL byp_next_cycle: got v=%b d=%h a=%h want v=1 d=deadbeef a=40",
                     bus.instr_valid_o, bus.instr_o, bus.instr_addr_o);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] exp_addr, prev_addr;
        logic        prev_pend, prev_redir, redir;
        int          consumed;
        do_reset();
        exp_addr = 32'h0;
        prev_addr = 32'h0;
        prev_pend = 1'b0;
        prev_redir = 1'b0;
        consumed = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            req = ($urandom_range(0, 9) < 8);
            bus.imem_ready_i = ($urandom_range(0, 2) != 0);
            bus.instr_ready_i = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 24) == 0);
            target_valid = redir;
            target_addr = $urandom & 32'h0000_0FFF;
            #1;
            if (prev_pend) begin
                checks++;
                if (bus.imem_valid_o !== 1'b1 || bus.imem_addr_o !== prev_addr) begin
                    errors++;
                    $display("FAIL rnd_hold@%0d: got v=%b a=%h want v=1 a=%h", i,
                             bus.imem_valid_o, bus.imem_addr_o, prev_addr);
                end
            end
`ifndef FETCH_BYPASS_EN
            if (prev_redir) begin
                checks++;
                if (bus.instr_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_flush@%0d: got v=%b want 0", i, bus.instr_valid_o);
                end
            end
`endif
            if (redir) begin
                exp_addr = {target_addr[31:2], 2'b00};
            end else if (bus.instr_valid_o && bus.instr_ready_i) begin
                checks++;
                if (bus.instr_addr_o !== exp_addr || bus.instr_o !== mem_word(exp_addr)) begin
                    errors++;
                    $display("FAIL rnd_stream@%0d: got a=%h d=%h want a=%h d=%h", i,
                             bus.instr_addr_o, bus.instr_o, exp_addr, mem_word(exp_addr));
                end
                exp_addr = exp_addr + 32'd4;
                consumed++;
            end
            prev_pend = bus.imem_valid_o && !bus.imem_ready_i;
            prev_addr = bus.imem_addr_o;
            prev_redir = redir;
        end
        checks++;
        if (consumed < 20) begin
            errors++; $display("FAIL rnd_progress: got %0d consumed want >= 20", consumed);
        end
        target_valid = 1'b0;
        req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_fill();
        test_redirect_discard();
        test_redirect_coincide();
        test_wrap();
        test_bypass();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised successor to the core's single-word fetch stage. Decouples instruction memory from the decoder with a DEPTH-entry prefetch FIFO holding {addr, instr} pairs, so fetch continues under decode backpressure. Handles redirects (branch/jump/trap targets) with FIFO flush and safe discard of an in-flight memory response. Sits between imem and the decoder in riscv_core.

Parameters:
ADDR_WIDTH, 32, instruction address width
WORD_WIDTH, 32, instruction word width
DEPTH, 4, prefetch FIFO entries (power of 2, >= 2)
RESET_ADDR, 32'h00000000, first fetch address after reset

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
req_i  input  1  fetch enable; new imem requests issued only while high
target_addr_i  input  ADDR_WIDTH  redirect target
target_valid_i  input  1  redirect strobe, single-cycle
instr_o  output  WORD_WIDTH  head instruction
instr_addr_o  output  ADDR_WIDTH  address of instr_o
instr_valid_o  output  1  instr_o/instr_addr_o valid
instr_ready_i  input  1  consumer accepts head this cycle
imem_valid_o  output  1  memory request valid
imem_ready_i  input  1  memory completes request; imem_rdata_i valid this cycle
imem_addr_o  output  ADDR_WIDTH  request address (word aligned)
imem_wdata_o  output  WORD_WIDTH  tied 0
imem_we_o  output  4  tied 4'b0000
imem_rdata_i  input  WORD_WIDTH  read data

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on rst_n. Reset (including mid-transaction) immediately clears: imem_valid_o=0, instr_valid_o=0, instr_o=0, instr_addr_o=0, FIFO count=0, discard flag=0, fetch_pc=RESET_ADDR, state=IDLE. imem_addr_o=fetch_pc.
- FSM: IDLE, BUSY (request outstanding), DISCARD (outstanding request whose response must be dropped).
- IDLE -> BUSY when req_i && count < DEPTH; imem_valid_o asserts combinationally in that cycle, imem_addr_o=fetch_pc.
- BUSY: imem_valid_o and imem_addr_o held stable until imem_ready_i, regardless of req_i. On valid&&ready: push {fetch_pc, imem_rdata_i}; fetch_pc += 4 (modulo 2^ADDR_WIDTH). Back-to-back: if req_i && space remains after the push/pop, stay in BUSY and issue the next address in the next cycle.
- One outstanding request maximum. Issue is gated by count < DEPTH at issue time, so the FIFO never overflows.
- Output: head of FIFO. instr_valid_o = (count != 0). Pop on instr_valid_o && instr_ready_i. Simultaneous push and pop leaves count unchanged.
- Redirect (target_valid_i=1), which has priority over all other events:
  - FIFO flushed; a same-cycle pop or push is ignored.
  - fetch_pc <= {target_addr_i[ADDR_WIDTH-1:2], 2'b00}.
  - instr_valid_o=0 from the next cycle.
  - If a request is pending without ready this cycle: go to DISCARD and keep imem_valid_o/imem_addr_o held at the old address until ready. The response is dropped, then the FSM goes to IDLE and fetches the target.
  - If valid&&ready coincides with the redirect: the response is dropped and the next request uses the target.
  - With no outstanding request: imem_addr_o=target from the next cycle.
  - A redirect while in DISCARD updates fetch_pc only.
- Latency (macro off): response at cycle N -> instr_valid_o at N+1.
- req_i low: no new issue; buffered entries still drain.

Optional Feature:
FETCH_BYPASS_EN:
- Defined: when count==0, not in DISCARD, no redirect, and valid&&ready, the response drives instr_o/instr_addr_o/instr_valid_o combinationally in the same cycle. If instr_ready_i, it is consumed and not pushed; otherwise it is pushed. Zero-cycle fetch-to-decode latency.
- Undefined: outputs come from FIFO registers only; 1-cycle latency.

Test Plan:
- Reset, RESET_ADDR=0, req_i=1, imem_ready_i=1, instr_ready_i=1 -> imem_addr_o sequence 0x0,0x4,0x8,0xC; instr_addr_o follows with matching rdata, 1 cycle later (macro off).
- DEPTH=4, instr_ready_i=0, imem_ready_i=1 -> exactly 4 transactions, then imem_valid_o=0. One pop -> exactly one further request at 0x10.
- Request at 0x10 with imem_ready_i=0; target_valid_i with 0x100; ready after 3 cycles -> imem_addr_o stays 0x10 until ready, that data never appears on instr_o, next request 0x100, first instr_addr_o=0x100.
- Redirect to 0x102 coinciding with valid&&ready at 0x20 and a pop -> response dropped, FIFO empty next cycle, next imem_addr_o=0x100.
- ADDR_WIDTH=8, RESET_ADDR=0xFC -> requests 0xFC then 0x00 (wrap).
- FIFO empty, response 0xDEADBEEF at 0x40, instr_ready_i=1 -> with FETCH_BYPASS_EN, instr_valid_o the same cycle and count stays 0; without it, instr_valid_o the next cycle.
